eth_gmii_tx_framer: RTL

Transmit-side GMII/MII framer for the 1G MAC. It converts a byte-wide AXI-stream frame from the TX FIFO into a GMII transmit stream by adding the preamble and SFD, zero-padding short frames, and appending the FCS. It also enforces the inter-frame gap and handles underflow and bad-frame aborts. It runs entirely in the tx_clk domain; status pulses are crossed to the logic clock elsewhere.

---
 rtl/eth_gmii_tx_framer_if.sv | 24 ++
 rtl/eth_gmii_tx_framer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/eth_gmii_tx_framer_if.sv
// Byte-wide AXI-stream link from the TX FIFO into the GMII framer.
interface eth_gmii_tx_framer_if;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tready;
  logic       tlast;
  logic       tuser;

  modport master (
    output tdata,
    output tvalid,
    output tlast,
    output tuser,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    input  tuser,
    output tready
  );
endinterface

// File: rtl/eth_gmii_tx_framer.sv
// GMII/MII transmit framer: preamble/SFD, zero padding, FCS, inter-frame gap,
// underflow and bad-frame aborts. Everything advances on clk_enable byte strobes.
module eth_gmii_tx_framer #(
  parameter int unsigned ENABLE_PADDING   = 1,
  parameter int unsigned MIN_FRAME_LENGTH = 64,
  parameter int unsigned MIN_IFG          = 12
) (
  input  logic                tx_clk,
  input  logic                tx_rst,
  eth_gmii_tx_framer_if.slave s_axis,
  input  logic                clk_enable,
  input  logic                mii_select,
  input  logic [7:0]          ifg_delay,
  output logic [7:0]          gmii_txd,
  output logic                gmii_tx_en,
  output logic                gmii_tx_er,
  output logic                error_underflow,
  output logic                start_packet
);

  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned NIB_W     = 4;
  localparam int unsigned CNT_W     = 16;
  localparam int unsigned CRC_W     = 32;
  localparam int unsigned PRE_W     = 3;
  localparam int unsigned FCS_W     = 2;
  localparam int unsigned PAD_BYTES = MIN_FRAME_LENGTH - 4;

  localparam logic [BYTE_W-1:0] PRE_BYTE     = 8'h55;
  localparam logic [BYTE_W-1:0] SFD_BYTE     = 8'hD5;
  localparam logic [PRE_W-1:0]  SFD_SLOT     = 3'd7;
  localparam logic [CRC_W-1:0]  CRC_INIT     = 32'hFFFF_FFFF;
  localparam logic [CRC_W-1:0]  CRC_POLY_REF = 32'hEDB8_8320;
  localparam logic [CNT_W-1:0]  CNT_MAX      = 16'hFFFF;
  localparam logic [FCS_W-1:0]  FCS_LAST     = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    PAYLOAD,
    PAD,
    FCS,
    WAIT_END,
    IFG
  } state_t;

  state_t             state;
  logic [PRE_W-1:0]   pre_cnt;
  logic [CNT_W-1:0]   byte_cnt;
  logic [FCS_W-1:0]   fcs_cnt;
  logic [BYTE_W-1:0]  ifg_cnt;
  logic [CRC_W-1:0]   crc;
  logic               tready_q;
  logic [NIB_W-1:0]   mii_hi;

  logic [BYTE_W-1:0]  txd_nxt;
  logic [CRC_W-1:0]   crc_nxt;
  logic [CNT_W-1:0]   byte_cnt_inc;
  logic [BYTE_W-1:0]  ifg_load;
  logic               pad_go;
  logic               pad_done;

  // Reflected CRC-32 (poly 0x04C11DB7) folded over one byte, LSB first.
  function automatic logic [CRC_W-1:0] crc32_byte(input logic [CRC_W-1:0] c,
                                                  input logic [BYTE_W-1:0] d);
    logic [CRC_W-1:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < BYTE_W; i++) begin
      r = r[0] ? ((r >> 1) ^ CRC_POLY_REF) : (r >> 1);
    end
    return r;
  endfunction

  assign s_axis.tready = tready_q;

  assign crc_nxt      = crc32_byte(crc, txd_nxt);
  assign byte_cnt_inc = (byte_cnt == CNT_MAX) ? byte_cnt : byte_cnt + 16'd1;
  assign ifg_load     = (ifg_delay < 8'(MIN_IFG)) ? 8'(MIN_IFG) : ifg_delay;
  assign pad_go       = (ENABLE_PADDING != 0) && (byte_cnt_inc < 16'(PAD_BYTES));
  assign pad_done     = (byte_cnt_inc >= 16'(PAD_BYTES));

  // Byte to put on the line at the next byte strobe.
  always_comb begin
    txd_nxt = '0;
    case (state)
      IDLE:     if (s_axis.tvalid) txd_nxt = PRE_BYTE;
      PREAMBLE: txd_nxt = (pre_cnt == SFD_SLOT) ? SFD_BYTE : PRE_BYTE;
      PAYLOAD:  if (s_axis.tvalid) txd_nxt = s_axis.tdata;
      FCS:      txd_nxt = ~crc[{fcs_cnt, 3'b000} +: BYTE_W];
      default:  txd_nxt = '0;
    endcase
  end

  // Framing state machine with registered line outputs and MII nibble replay.
  always_ff @(posedge tx_clk or posedge tx_rst) begin
    if (tx_rst) begin
      state           <= IDLE;
      pre_cnt         <= '0;
      byte_cnt        <= '0;
      fcs_cnt         <= '0;
      ifg_cnt         <= '0;
      crc             <= CRC_INIT;
      tready_q        <= 1'b0;
      mii_hi          <= '0;
      gmii_txd        <= '0;
      gmii_tx_en      <= 1'b0;
      gmii_tx_er      <= 1'b0;
      error_underflow <= 1'b0;
      start_packet    <= 1'b0;
    end else begin
      start_packet    <= 1'b0;
      error_underflow <= 1'b0;
      if (clk_enable) begin
        gmii_txd <= mii_select ? {4'h0, txd_nxt[3:0]} : txd_nxt;
        mii_hi   <= txd_nxt[7:4];
        case (state)
          IDLE: begin
            gmii_tx_en <= 1'b0;
            gmii_tx_er <= 1'b0;
            tready_q   <= 1'b0;
            if (s_axis.tvalid) begin
              // First preamble byte goes out on this strobe.
              state      <= PREAMBLE;
              pre_cnt    <= 3'd1;
              byte_cnt   <= '0;
              crc        <= CRC_INIT;
              gmii_tx_en <= 1'b1;
            end
          end

          PREAMBLE: begin
            gmii_tx_en <= 1'b1;
            gmii_tx_er <= 1'b0;
            if (pre_cnt == SFD_SLOT) begin
              start_packet <= 1'b1;
              tready_q     <= 1'b1;
              state        <= PAYLOAD;
            end else begin
              pre_cnt <= pre_cnt + 3'd1;
            end
          end

          PAYLOAD: begin
            gmii_tx_en <= 1'b1;
            if (s_axis.tvalid) begin
              gmii_tx_er <= s_axis.tlast & s_axis.tuser;
              crc        <= crc_nxt;
              byte_cnt   <= byte_cnt_inc;
              if (s_axis.tlast) begin
                tready_q <= 1'b0;
                fcs_cnt  <= '0;
                if (s_axis.tuser) begin
                  state   <= IFG;
                  ifg_cnt <= ifg_load;
                end else if (pad_go) begin
                  state <= PAD;
                end else begin
                  state <= FCS;
                end
              end
            end else begin
              // FIFO ran dry mid-frame: poison the frame and drain the rest.
              gmii_tx_er      <= 1'b1;
              error_underflow <= 1'b1;
              state           <= WAIT_END;
            end
          end

          PAD: begin
            gmii_tx_en <= 1'b1;
            gmii_tx_er <= 1'b0;
            crc        <= crc_nxt;
            byte_cnt   <= byte_cnt_inc;
            if (pad_done) begin
              state   <= FCS;
              fcs_cnt <= '0;
            end
          end

          FCS: begin
            gmii_tx_en <= 1'b1;
            gmii_tx_er <= 1'b0;
            fcs_cnt    <= fcs_cnt + 2'd1;
            if (fcs_cnt == FCS_LAST) begin
              state   <= IFG;
              ifg_cnt <= ifg_load;
            end
          end

          WAIT_END: begin
            gmii_tx_en <= 1'b0;
            gmii_tx_er <= 1'b0;
            if (s_axis.tvalid && s_axis.tlast) begin
              tready_q <= 1'b0;
              state    <= IFG;
              ifg_cnt  <= ifg_load;
            end
          end

          IFG: begin
            gmii_tx_en <= 1'b0;
            gmii_tx_er <= 1'b0;
            tready_q   <= 1'b0;
            if (ifg_cnt <= 8'd1) begin
              state <= IDLE;
            end else begin
              ifg_cnt <= ifg_cnt - 8'd1;
            end
          end

          default: begin
            state      <= IDLE;
            gmii_tx_en <= 1'b0;
            gmii_tx_er <= 1'b0;
            tready_q   <= 1'b0;
          end
        endcase
      end else if (mii_select) begin
        // Second half of the MII byte time carries the high nibble.
        gmii_txd <= {4'h0, mii_hi};
      end
    end
  end

endmodule
